hash_bits_off_counter: RTL

//   Multi-bit-per-cycle successor to the serial hash bits-off shift register.

---
 rtl/hash_bits_off_counter_if.sv | 25 ++
 rtl/hash_bits_off_counter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/hash_bits_off_counter_if.sv
// Request/result bundle between the hash core side and the bits-off counter.
// The master drives a hash XOR vector plus control; the slave returns scores.
interface hash_bits_off_counter_if #(
  parameter int WIDTH = 1024,
  parameter int CNT_W = 11
);
  logic             start;
  logic [WIDTH-1:0] hash_xor;
  logic             clear_best;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] bits_off;
  logic [CNT_W-1:0] best;
  logic             new_best;

  modport master (
    output start, hash_xor, clear_best,
    input  busy, done, bits_off, best, new_best
  );

  modport slave (
    input  start, hash_xor, clear_best,
    output busy, done, bits_off, best, new_best
  );
endinterface

// File: rtl/hash_bits_off_counter.sv
// Counts bits set in a hash XOR vector, BITS_PER_CYCLE bits per clock, and keeps
// the lowest score seen since reset or the last clear.
module hash_bits_off_counter #(
  parameter int WIDTH          = 1024,
  parameter int BITS_PER_CYCLE = 8,
  parameter int CNT_W          = 11
) (
  input logic                    clk,
  input logic                    rst,
  hash_bits_off_counter_if.slave bus
);
  localparam int                 N          = WIDTH / BITS_PER_CYCLE;
  localparam int                 CHUNK_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(N - 1);
  localparam logic [CNT_W-1:0]   BEST_INIT  = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] popcount(input logic [BITS_PER_CYCLE-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

  state_t               state_r;
  state_t               state_nxt_s;
  logic [WIDTH-1:0]     sr_r;
  logic [CNT_W-1:0]     acc_r;
  logic [CHUNK_W-1:0]   chunk_r;
  logic [CNT_W-1:0]     bits_off_r;
  logic [CNT_W-1:0]     best_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 new_best_r;
  logic                 start_ok_s;
  logic                 finish_s;
  logic                 lower_s;
  logic [CNT_W-1:0]     acc_sum_s;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; start is only honoured outside COUNT, so no queueing
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) state_nxt_s = COUNT;
        else           state_nxt_s = IDLE;
      end
      COUNT: begin
        if (chunk_r == LAST_CHUNK) state_nxt_s = DONE;
        else                       state_nxt_s = COUNT;
      end
      DONE: begin
        if (bus.start) state_nxt_s = COUNT;
        else           state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output/datapath decode; a coinciding clear suppresses the new-best pulse
  always_comb begin
    start_ok_s = bus.start && ((state_r == IDLE) || (state_r == DONE));
    finish_s   = (state_r == COUNT) && (chunk_r == LAST_CHUNK);
    acc_sum_s  = acc_r + popcount(sr_r[BITS_PER_CYCLE-1:0]);
    lower_s    = finish_s && !bus.clear_best && (acc_sum_s < best_r);
  end

  // Shift register, accumulator and registered result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_r       <= '0;
      acc_r      <= '0;
      chunk_r    <= '0;
      bits_off_r <= '0;
      best_r     <= BEST_INIT;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      new_best_r <= 1'b0;
    end else begin
      if (start_ok_s) begin
        sr_r    <= bus.hash_xor;
        acc_r   <= '0;
        chunk_r <= '0;
      end else if (state_r == COUNT) begin
        sr_r    <= sr_r >> BITS_PER_CYCLE;
        acc_r   <= acc_sum_s;
        chunk_r <= chunk_r + CHUNK_W'(1);
      end
      if (finish_s) begin
        bits_off_r <= acc_sum_s;
      end
      if (bus.clear_best) begin
        best_r <= BEST_INIT;
      end else if (lower_s) begin
        best_r <= acc_sum_s;
      end
      busy_r     <= (state_nxt_s == COUNT);
      done_r     <= (state_nxt_s == DONE);
      new_best_r <= lower_s;
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.bits_off = bits_off_r;
  assign bus.best     = best_r;
  assign bus.new_best = new_best_r;
endmodule
